mt_reg_file_banked: RTL and testbench

Multithreaded integer register file with a configurable number of thread groups. Each group holds NUM_THREADS × NUM_REGS registers. Each cycle, one (group, thread) context is latched into a read snapshot, and the two asynchronous read ports are served from that snapshot. Sits in the multithreaded core's decode stage. Adds two things: a post-reset clear sequencer with a `ready` handshake, and optional same-cycle write forwarding into the snapshot.

---
 rtl/mt_reg_file_banked.sv | 147 ++++++++++++++
 tb/tb_mt_reg_file_banked.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mt_reg_file_banked.sv
// mt_reg_file_banked
//   Multithreaded integer register file for the decode stage. Storage is
//   NUM_GROUPS x NUM_THREADS rows of NUM_REGS x DATA_WIDTH. Each cycle one
//   (group, thread) row is latched into a snapshot. The two asynchronous
//   read ports are served from that snapshot. Register 0 always reads as 0.
//   After reset a clear sequencer zeroes one row per cycle. ready_o rises
//   when the last row has been cleared, and writes are only accepted once
//   ready_o is high.
//
//   Optional feature: define MT_RF_BYPASS_EN to forward a same-context write
//   into the snapshot on the same edge. Undefined (default) means no
//   forwarding.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-high reset
//   write_enable_i   write request (ignored while clearing)
//   tgrp_write_i     write group
//   tid_write_i      write thread
//   a3_i             write register address (low BITS_REGS bits used)
//   wd3_i            write data
//   tgrp_read_i      group loaded into the snapshot
//   tid_read_i       thread loaded into the snapshot
//   a1_i, a2_i       read addresses (low BITS_REGS bits used)
//   rd1_o, rd2_o     read data from the snapshot
//   ready_o          high once the clear sequence has completed

`timescale 1ns/1ps

module mt_reg_file_banked #(
  parameter int NUM_THREADS  = 8,
  parameter int NUM_GROUPS   = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 16,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int BITS_GROUPS  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  parameter int BITS_REGS    = $clog2(NUM_REGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    write_enable_i,
  input  logic [BITS_GROUPS-1:0]  tgrp_write_i,
  input  logic [BITS_THREADS-1:0] tid_write_i,
  input  logic [4:0]              a3_i,
  input  logic [DATA_WIDTH-1:0]   wd3_i,
  input  logic [BITS_GROUPS-1:0]  tgrp_read_i,
  input  logic [BITS_THREADS-1:0] tid_read_i,
  input  logic [4:0]              a1_i,
  input  logic [4:0]              a2_i,
  output logic [DATA_WIDTH-1:0]   rd1_o,
  output logic [DATA_WIDTH-1:0]   rd2_o,
  output logic                    ready_o
);

  localparam int ROWS  = NUM_GROUPS * NUM_THREADS;
  localparam int PTR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      clear_ptr_q, clear_ptr_d;

  logic [DATA_WIDTH-1:0] mem_q  [ROWS][NUM_REGS];
  logic [DATA_WIDTH-1:0] snap_q [NUM_REGS];

  logic [PTR_W-1:0]      wr_row, rd_row;
  logic                  wr_valid, rd_valid;
  logic [BITS_REGS-1:0]  wa, ra1, ra2;

  // Ids beyond the populated range (non-power-of-two configs) must never
  // alias onto a real row, so they are qualified separately.
  always_comb begin
    wr_valid = (int'(tgrp_write_i) < NUM_GROUPS) && (int'(tid_write_i) < NUM_THREADS);
    rd_valid = (int'(tgrp_read_i) < NUM_GROUPS) && (int'(tid_read_i) < NUM_THREADS);
    wr_row   = PTR_W'(int'(tgrp_write_i) * NUM_THREADS + int'(tid_write_i));
    rd_row   = PTR_W'(int'(tgrp_read_i) * NUM_THREADS + int'(tid_read_i));
    wa       = a3_i[BITS_REGS-1:0];
    ra1      = a1_i[BITS_REGS-1:0];
    ra2      = a2_i[BITS_REGS-1:0];
  end

  // FSM: next state and clear pointer
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clear_ptr_d = clear_ptr_q + PTR_W'(1);
        if (int'(clear_ptr_q) == ROWS - 1) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Array storage has no reset; the clear sequencer zeroes it row by row.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clear_ptr_q] <= '{default: '0};
    end else if (write_enable_i && wr_valid) begin
      mem_q[wr_row][wa] <= wd3_i;
    end
  end

  // Snapshot samples the pre-edge array; forwarding (when enabled) overrides
  // the one entry being written in the selected context.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_q <= '{default: '0};
    end else if (state_q == ST_RUN) begin
      if (rd_valid) snap_q <= mem_q[rd_row];
      else          snap_q <= '{default: '0};
`ifdef MT_RF_BYPASS_EN
      if (write_enable_i && wr_valid && rd_valid &&
          (tgrp_write_i == tgrp_read_i) && (tid_write_i == tid_read_i))
        snap_q[wa] <= wd3_i;
`endif
    end else begin
      snap_q <= '{default: '0};
    end
  end

  assign rd1_o   = (ra1 == '0) ? '0 : snap_q[ra1];
  assign rd2_o   = (ra2 == '0) ? '0 : snap_q[ra2];
  assign ready_o = (state_q == ST_RUN);

  generate
    if (BITS_REGS < 5) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^{a1_i[4:BITS_REGS], a2_i[4:BITS_REGS], a3_i[4:BITS_REGS]};
    end
  endgenerate

endmodule

// File: tb/tb_mt_reg_file_banked.sv
`timescale 1ns/1ps

module tb_mt_reg_file_banked;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [0:0]  tgrp_w = '0;
  logic [2:0]  tid_w = '0;
  logic [4:0]  a3 = '0;
  logic [31:0] wd3 = '0;
  logic [0:0]  tgrp_r = '0;
  logic [2:0]  tid_r = '0;
  logic [4:0]  a1 = '0;
  logic [4:0]  a2 = '0;
  logic [31:0] rd1, rd2;
  logic        ready;

  int vectors = 0;
  int errs = 0;

  mt_reg_file_banked dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .write_enable_i (we),
    .tgrp_write_i   (tgrp_w),
    .tid_write_i    (tid_w),
    .a3_i           (a3),
    .wd3_i          (wd3),
    .tgrp_read_i    (tgrp_r),
    .tid_read_i     (tid_r),
    .a1_i           (a1),
    .a2_i           (a2),
    .rd1_o          (rd1),
    .rd2_o          (rd2),
    .ready_o        (ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int g, input int t, input int r, input logic [31:0] d);
    we = 1'b1; tgrp_w = 1'(g); tid_w = 3'(t); a3 = 5'(r); wd3 = d;
    tick();
    we = 1'b0;
  endtask

  task automatic select(input int g, input int t);
    tgrp_r = 1'(g); tid_r = 3'(t);
    tick();
  endtask

  // Clear sequence: ready low for 16 edges after deassert, high on the 16th.
  // Writes are held active throughout to prove they are dropped.
  task automatic clear_run(input string tag);
    for (int i = 1; i <= 16; i++) begin
      we = 1'b1; wd3 = 32'hDEADBEEF;
      tgrp_w = 1'(i); tid_w = 3'(i); a3 = 5'(i % 16);
      tick();
      check(tag, {31'd0, ready}, (i == 16) ? 32'd1 : 32'd0);
    end
    we = 1'b0;
  endtask

  task automatic scan_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      for (int t = 0; t < 8; t++) begin
        select(g, t);
        for (int r = 0; r < 8; r++) begin
          a1 = 5'(r); a2 = 5'(r + 8);
          #1;
          check(tag, rd1, 32'd0);
          check(tag, rd2, 32'd0);
        end
      end
    end
  endtask

  initial begin
    // Reset asserted before any clock edge: outputs must already be zero.
    #1 rst = 1'b1;
    a1 = 5'd5; a2 = 5'd7;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_rd1", rd1, 32'd0);
    check("rst_rd2", rd2, 32'd0);
    we = 1'b1; wd3 = 32'hDEADBEEF;
    tick(); tick();
    rst = 1'b0;

    clear_run("clear_ready");
    scan_zero("clear_zero");

    // Isolation between groups and threads
    do_write(0, 3, 5, 32'h11111111);
    do_write(1, 3, 5, 32'h22222222);
    a1 = 5'd5;
    select(0, 3); check("iso_g0t3", rd1, 32'h11111111);
    select(1, 3); check("iso_g1t3", rd1, 32'h22222222);
    select(0, 4); check("iso_g0t4", rd1, 32'h00000000);
    select(0, 3);
    a1 = 5'b10101; #1;
    check("upper_addr_ignored", rd1, 32'h11111111);

    // Register zero
    do_write(0, 2, 0, 32'hFFFFFFFF);
    select(0, 2);
    a1 = 5'd0; #1;
    check("r0_read", rd1, 32'd0);
    a1 = 5'b10000; #1;
    check("r0_alias", rd1, 32'd0);

    // Write latency with (0,1) selected continuously
    tgrp_r = 1'b0; tid_r = 3'd1; a2 = 5'd7;
    do_write(0, 1, 7, 32'h12345678);
    tick();
    check("lat_old", rd2, 32'h12345678);
    do_write(0, 1, 7, 32'hA5A5A5A5);
`ifdef MT_RF_BYPASS_EN
    check("lat_edge_k", rd2, 32'hA5A5A5A5);
`else
    check("lat_edge_k", rd2, 32'h12345678);
`endif
    tick();
    check("lat_edge_k1", rd2, 32'hA5A5A5A5);

    // Write to another context while (0,1) is selected has no effect on it
    do_write(1, 1, 7, 32'hBBBBBBBB);
    check("other_ctx_same_edge", rd2, 32'hA5A5A5A5);
    tick();
    check("other_ctx_next_edge", rd2, 32'hA5A5A5A5);

    // Back-to-back writes, last one wins
    a1 = 5'd9;
    do_write(0, 1, 9, 32'h00000001);
    do_write(0, 1, 9, 32'h00000002);
    tick(); tick();
    check("b2b_last_wins", rd1, 32'h00000002);
    select(1, 1);
    check("other_ctx_stored", rd2, 32'hBBBBBBBB);
    select(0, 1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("async_ready", {31'd0, ready}, 32'd0);
    check("async_rd1", rd1, 32'd0);
    check("async_rd2", rd2, 32'd0);
    tick();
    rst = 1'b0;
    clear_run("reclear_ready");
    scan_zero("reclear_zero");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
